// File: rtl/nand_nor_arbiter.sv
// Round-robin arbiter sharing one external NAND/NOR cell among N_REQ requesters.
// Operands are latched at grant, held SETTLE_CYC cycles, then both results are sampled and checked.
module nand_nor_arbiter #(
   parameter int N_REQ      = 4,
   parameter int SETTLE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] a,
   input  logic [N_REQ-1:0] b,
   input  logic             gate_nand,
   input  logic             gate_nor,
   output logic             gate_a,
   output logic             gate_b,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] rsp_valid,
   output logic             rsp_nand,
   output logic             rsp_nor,
   output logic             rsp_err,
   output logic             sticky_err,
   output logic [7:0]       err_cnt,
   output logic             busy
);
   localparam int PW = $clog2(N_REQ);
   localparam int CW = 4;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;

   state_t           r_state, w_state_nxt;
   logic [PW-1:0]    r_ptr, w_ptr_nxt;
   logic [PW-1:0]    r_win, w_win_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [N_REQ-1:0] r_grant, w_grant_nxt;
   logic [N_REQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
   logic             r_gate_a, w_gate_a_nxt;
   logic             r_gate_b, w_gate_b_nxt;
   logic             r_rsp_nand, w_rsp_nand_nxt;
   logic             r_rsp_nor, w_rsp_nor_nxt;
   logic             r_rsp_err, w_rsp_err_nxt;
   logic             r_sticky, w_sticky_nxt;
   logic [7:0]       r_err_cnt, w_err_cnt_nxt;
   logic             r_busy, w_busy_nxt;

   logic [N_REQ-1:0] w_elig;
   logic             w_hit;
   logic [PW-1:0]    w_win;
   logic             w_mis;

   // The requester in its response cycle is masked so it cannot be re-granted immediately.
   always_comb begin
      logic [PW-1:0] idx;
      w_elig = req & ~r_rsp_valid;
      w_hit  = 1'b0;
      w_win  = '0;
      idx    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = PW'((int'(r_ptr) + i) % N_REQ);
         if (!w_hit && w_elig[idx]) begin
            w_hit = 1'b1;
            w_win = idx;
         end
      end
   end

   assign w_mis = (gate_nand != ~(r_gate_a & r_gate_b)) | (gate_nor != ~(r_gate_a | r_gate_b));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_hit) w_state_nxt = S_SETTLE;
         S_SETTLE: if (r_cnt == '0) w_state_nxt = S_SAMPLE;
         S_SAMPLE: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_ptr_nxt       = r_ptr;
      w_win_nxt       = r_win;
      w_cnt_nxt       = r_cnt;
      w_grant_nxt     = r_grant;
      w_rsp_valid_nxt = '0;
      w_gate_a_nxt    = r_gate_a;
      w_gate_b_nxt    = r_gate_b;
      w_rsp_nand_nxt  = r_rsp_nand;
      w_rsp_nor_nxt   = r_rsp_nor;
      w_rsp_err_nxt   = 1'b0;
      w_sticky_nxt    = r_sticky;
      w_err_cnt_nxt   = r_err_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               w_grant_nxt  = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
               w_gate_a_nxt = a[w_win];
               w_gate_b_nxt = b[w_win];
               w_cnt_nxt    = CW'(SETTLE_CYC - 1);
               w_win_nxt    = w_win;
            end
         end
         S_SETTLE: begin
            if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
         end
         S_SAMPLE: begin
            w_rsp_nand_nxt  = gate_nand;
            w_rsp_nor_nxt   = gate_nor;
            w_rsp_valid_nxt = r_grant;
            w_grant_nxt     = '0;
            w_ptr_nxt       = (r_win == PW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
            w_rsp_err_nxt   = w_mis;
            if (w_mis) begin
               w_sticky_nxt = 1'b1;
               if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
            end
         end
         default: ;
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_win       <= '0;
         r_cnt       <= '0;
         r_grant     <= '0;
         r_rsp_valid <= '0;
         r_gate_a    <= 1'b0;
         r_gate_b    <= 1'b0;
         r_rsp_nand  <= 1'b0;
         r_rsp_nor   <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_sticky    <= 1'b0;
         r_err_cnt   <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_ptr       <= w_ptr_nxt;
         r_win       <= w_win_nxt;
         r_cnt       <= w_cnt_nxt;
         r_grant     <= w_grant_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_gate_a    <= w_gate_a_nxt;
         r_gate_b    <= w_gate_b_nxt;
         r_rsp_nand  <= w_rsp_nand_nxt;
         r_rsp_nor   <= w_rsp_nor_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_sticky    <= w_sticky_nxt;
         r_err_cnt   <= w_err_cnt_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign gate_a     = r_gate_a;
   assign gate_b     = r_gate_b;
   assign grant      = r_grant;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_nand   = r_rsp_nand;
   assign rsp_nor    = r_rsp_nor;
   assign rsp_err    = r_rsp_err;
   assign sticky_err = r_sticky;
   assign err_cnt    = r_err_cnt;
   assign busy       = r_busy;
endmodule

// File: tb/tb_nand_nor_arbiter.sv
// Bench for nand_nor_arbiter: directed transactions, a behavioural NAND/NOR cell with a
// stuck-at-0 NOR fault option, and a response queue drained by an independent monitor.
module tb_nand_nor_arbiter;
   localparam int N = 4;
   localparam int S = 2;
   localparam int W = N + 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req, a, b;
   logic         gate_nand, gate_nor, gate_a, gate_b;
   logic [N-1:0] grant, rsp_valid;
   logic         rsp_nand, rsp_nor, rsp_err, sticky_err, busy;
   logic [7:0]   err_cnt;
   logic         inj_nor0;
   logic         mon_en;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;

   always #5 clk = ~clk;

   // Shared cell model; inj_nor0 forces the NOR output low.
   assign gate_nand = ~(gate_a & gate_b);
   assign gate_nor  = inj_nor0 ? 1'b0 : ~(gate_a | gate_b);

   nand_nor_arbiter #(.N_REQ(N), .SETTLE_CYC(S)) dut (
      .clk(clk), .rst(rst), .req(req), .a(a), .b(b),
      .gate_nand(gate_nand), .gate_nor(gate_nor),
      .gate_a(gate_a), .gate_b(gate_b), .grant(grant), .rsp_valid(rsp_valid),
      .rsp_nand(rsp_nand), .rsp_nor(rsp_nor), .rsp_err(rsp_err),
      .sticky_err(sticky_err), .err_cnt(err_cnt), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic push_exp(input logic [N-1:0] oh, input logic n, input logic o, input logic e);
      exp_q.push_back({oh, n, o, e});
   endtask

   task automatic wait_grant(input logic want_high);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (((grant != '0) != want_high) && n < 20);
      check("wait_grant", 32'(grant != '0), 32'(want_high));
   endtask

   // Monitor: every response strobe must match the oldest expected entry.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check("rsp", 32'({rsp_valid, rsp_nand, rsp_nor, rsp_err}), 32'(mon_e));
            end
         end else begin
            check("rsp_err_idle", 32'(rsp_err), 32'(0));
         end
      end
   end

   initial begin
      logic [N-1:0] oh;
      rst = 1'b1; req = '0; a = '0; b = '0; inj_nor0 = 1'b0; mon_en = 1'b0;
      step();
      step();
      check("rst_grant", 32'(grant), 32'(0));
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_err_cnt", 32'(err_cnt), 32'(0));
      check("rst_gate_ab", 32'({gate_a, gate_b, sticky_err}), 32'(0));
      rst = 1'b0;
      mon_en = 1'b1;

      // Single request with a correct cell; req is dropped while granted.
      req = 4'b0001; a = 4'b0001; b = 4'b0001;
      push_exp(4'b0001, 1'b0, 1'b0, 1'b0);
      step();
      check("t1_grant0", 32'(grant), 32'(4'b0001));
      check("t1_gate_ab", 32'({gate_a, gate_b}), 32'(2'b11));
      check("t1_busy", 32'(busy), 32'(1));
      req = '0;
      step();
      check("t1_grant1", 32'(grant), 32'(4'b0001));
      step();
      check("t1_grant2", 32'(grant), 32'(4'b0001));
      step();
      check("t1_grant_end", 32'(grant), 32'(0));
      check("t1_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
      check("t1_busy_end", 32'(busy), 32'(0));
      step();
      check("t1_rsp_one_cycle", 32'(rsp_valid), 32'(0));

      // Round-robin with all requests held.
      do_reset();
      req = 4'b1111; a = 4'b0101; b = 4'b0011;
      push_exp(4'b0001, 1'b0, 1'b0, 1'b0);
      push_exp(4'b0010, 1'b1, 1'b0, 1'b0);
      push_exp(4'b0100, 1'b1, 1'b0, 1'b0);
      push_exp(4'b1000, 1'b1, 1'b1, 1'b0);
      push_exp(4'b0001, 1'b0, 1'b0, 1'b0);
      step();
      check("rr_grant0", 32'(grant), 32'(4'b0001));
      for (int k = 1; k <= 4; k++) begin
         repeat (3) step();
         check("rr_gap", 32'(grant), 32'(0));
         step();
         oh = 4'b0001 << (k % 4);
         check("rr_grant", 32'(grant), 32'(oh));
      end
      req = '0;
      repeat (4) step();

      // A lone requester is masked in its own response cycle.
      do_reset();
      req = 4'b0100; a = 4'b0100; b = 4'b0000;
      push_exp(4'b0100, 1'b1, 1'b0, 1'b0);
      push_exp(4'b0100, 1'b1, 1'b0, 1'b0);
      step();
      check("mask_grant0", 32'(grant), 32'(4'b0100));
      repeat (3) step();
      check("mask_rsp", 32'(rsp_valid), 32'(4'b0100));
      check("mask_grant_rsp", 32'(grant), 32'(0));
      step();
      check("mask_no_regrant", 32'(grant), 32'(0));
      step();
      check("mask_regrant", 32'(grant), 32'(4'b0100));
      req = '0;
      repeat (4) step();

      // Reset while in SETTLE aborts the transaction and rewinds the pointer.
      req = 4'b0100; a = 4'b0100; b = 4'b0100;
      step();
      check("abort_grant", 32'(grant), 32'(4'b0100));
      step();
      rst = 1'b1;
      step();
      check("abort_grant_clr", 32'(grant), 32'(0));
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_gate_a", 32'({gate_a, gate_b}), 32'(0));
      check("abort_rsp", 32'(rsp_valid), 32'(0));
      rst = 1'b0;
      req = 4'b1111; a = '0; b = '0;
      push_exp(4'b0001, 1'b1, 1'b1, 1'b0);
      step();
      check("abort_ptr0", 32'(grant), 32'(4'b0001));
      req = '0;
      repeat (5) step();

      // Operand changes after grant are ignored.
      req = 4'b0001; a = 4'b0001; b = 4'b0001;
      push_exp(4'b0001, 1'b0, 1'b0, 1'b0);
      step();
      check("stab_grant", 32'(grant), 32'(4'b0001));
      a = 4'b0000;
      step();
      check("stab_gate_a1", 32'(gate_a), 32'(1));
      req = '0;
      step();
      check("stab_gate_a2", 32'(gate_a), 32'(1));
      repeat (3) step();

      // Stuck-at-0 NOR fault: every transaction mismatches; counter saturates.
      inj_nor0 = 1'b1; a = '0; b = '0;
      for (int i = 0; i < 300; i++) begin
         push_exp(4'b0001, 1'b1, 1'b0, 1'b1);
         req = 4'b0001;
         wait_grant(1'b1);
         req = '0;
         if (i == 1) begin
            check("fault_cnt1", 32'(err_cnt), 32'(1));
            check("fault_sticky", 32'(sticky_err), 32'(1));
         end
         wait_grant(1'b0);
      end
      repeat (3) step();
      check("fault_cnt_sat", 32'(err_cnt), 32'(255));
      check("fault_sticky_end", 32'(sticky_err), 32'(1));
      do_reset();
      inj_nor0 = 1'b0;
      check("fault_rst_cnt", 32'(err_cnt), 32'(0));
      check("fault_rst_sticky", 32'(sticky_err), 32'(0));

      repeat (4) step();
      check("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
